// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter peripheral: register
// addresses, transmitter FSM states and the baud divider helper.
package uart_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Clocks per serial bit, truncating division.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter: baud counter, shift register and frame FSM.
// A start pulse while idle latches data and begins a frame on the next edge.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Frame sequencer with registered serial output and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= START;
            shreg   <= data;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter for the J1 I/O bus.
// Optional macro UART_LEDOUT_EN: when defined, ledout mirrors busy;
// otherwise ledout is tied low.
module uart_tx_peripheral
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        uart_tx,
  output logic        ledout
);

  logic       wr_hit;
  logic       wr_hit_q;
  logic       accept;
  logic       busy;
  logic [7:0] tx_byte;
  logic       unused_hi;

  assign unused_hi = ^d_in[15:8];

  assign wr_hit = cs & wr & (addr == ADDR_TXDATA);
  assign accept = wr_hit & ~wr_hit_q & ~busy;

  // Write-strobe edge history and the last accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_hit_q <= 1'b0;
      tx_byte  <= '0;
    end else begin
      wr_hit_q <= wr_hit;
      if (accept) tx_byte <= d_in[7:0];
    end
  end

  // Registered read mux; returns to zero whenever no read is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
    end else if (cs && rd) begin
      case (addr)
        ADDR_STATUS: d_out <= {15'b0, busy};
        ADDR_TXDATA: d_out <= {8'b0, tx_byte};
        default:     d_out <= '0;
      endcase
    end else begin
      d_out <= '0;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(accept),
    .data (d_in[7:0]),
    .tx   (uart_tx),
    .busy (busy)
  );

`ifdef UART_LEDOUT_EN
  assign ledout = busy;
`else
  assign ledout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Self-checking bench for uart_tx_peripheral at default parameters.
module tb_uart_tx_peripheral;

  localparam int N     = 434;
  localparam int FRAME = 10 * N;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0;
  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] d_out;
  logic        uart_tx;
  logic        ledout;

  always #5 clk = ~clk;

  uart_tx_peripheral dut (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .cs     (cs),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .d_out  (d_out),
    .uart_tx(uart_tx),
    .ledout (ledout)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: records when a frame was accepted and which byte;
  // the expected line level is derived arithmetically from elapsed clocks.
  int          ecnt = 0;
  logic        m_prev;
  logic        m_busy;
  logic [7:0]  m_byte;
  logic [15:0] m_dout;
  int          m_start;
  logic        m_hit;

  assign m_hit = cs & wr & (addr == 4'h2);

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev  <= 1'b0;
      m_busy  <= 1'b0;
      m_byte  <= 8'h00;
      m_dout  <= 16'h0000;
      m_start <= 0;
    end else begin
      m_prev <= m_hit;
      if (m_hit && !m_prev && !m_busy) begin
        m_byte  <= d_in[7:0];
        m_start <= ecnt;
        m_busy  <= 1'b1;
      end else if (m_busy && (ecnt - m_start == FRAME)) begin
        m_busy <= 1'b0;
      end
      if (!(cs && rd))       m_dout <= 16'h0000;
      else if (addr == 4'h0) m_dout <= {15'b0, m_busy};
      else if (addr == 4'h2) m_dout <= {8'h00, m_byte};
      else                   m_dout <= 16'h0000;
    end
  end

  function automatic logic exp_tx();
    int k, b;
    if (!m_busy) return 1'b1;
    k = ecnt - 1 - m_start;
    b = k / N;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic exp_led();
`ifdef UART_LEDOUT_EN
    return m_busy;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, ecnt);
    end
  endtask

  // Advance n clocks; after each edge compare every output with the model.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
      chk("tx", {15'b0, uart_tx}, {15'b0, exp_tx()});
      chk("ledout", {15'b0, ledout}, {15'b0, exp_led()});
      chk("d_out", d_out, m_dout);
    end
  endtask

  task automatic bus_idle();
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; d_in = '0;
  endtask

  // Hold a write strobe for 'hold' cycles, scrambling d_in after the first.
  task automatic write_byte(input logic [7:0] b, input int hold);
    cs = 1'b1; wr = 1'b1; addr = 4'h2; d_in = {8'h00, b};
    tick(1);
    for (int i = 1; i < hold; i++) begin
      d_in = 16'($urandom);
      tick(1);
    end
    bus_idle();
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [15:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick(1);
    chk(tag, d_out, exp);
    bus_idle();
  endtask

  initial begin
    logic [7:0] rb;

    // Reset held two cycles, then idle bus
    bus_idle();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(100);
    chk("reset_tx", {15'b0, uart_tx}, 16'h0001);
    chk("reset_dout", d_out, 16'h0000);
    chk("reset_led", {15'b0, ledout}, 16'h0000);

    // Single write held with changing data: one 0x26 frame
    cs = 1'b1; wr = 1'b1; addr = 4'h2; d_in = 16'h0026;
    tick(5);
    d_in = 16'h0000;
    tick(5);
    bus_idle();
    tick(1990);
    rd_chk(4'h0, 16'h0001, "status_mid");
    tick(FRAME - 2000);
    rd_chk(4'h0, 16'h0000, "status_after");
    rd_chk(4'h2, 16'h0026, "txdata_26");

    // Second byte
    cs = 1'b1; wr = 1'b1; addr = 4'h2; d_in = 16'h002D;
    tick(5);
    d_in = 16'h0000;
    tick(5);
    bus_idle();
    tick(FRAME);
    rd_chk(4'h2, 16'h002D, "txdata_2d");

    // Busy collision: 0xAA must be dropped
    write_byte(8'h55, 3);
    tick(1000);
    write_byte(8'hAA, 3);
    tick(FRAME);
    rd_chk(4'h2, 16'h0055, "collision");

    // Write landing in the final stop-bit cycle is ignored
    cs = 1'b1; wr = 1'b1; addr = 4'h2; d_in = 16'h003C;
    tick(1);
    bus_idle();
    tick(FRAME - 1);
    cs = 1'b1; wr = 1'b1; addr = 4'h2; d_in = 16'h00C3;
    tick(1);
    bus_idle();
    tick(5);
    rd_chk(4'h0, 16'h0000, "stopcycle_status");
    rd_chk(4'h2, 16'h003C, "stopcycle_byte");

    // Simultaneous read and write: read shows the pre-write byte
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'h2; d_in = 16'h0099;
    tick(1);
    chk("rdwr_prebyte", d_out, 16'h003C);
    bus_idle();
    tick(FRAME + 5);
    rd_chk(4'h2, 16'h0099, "rdwr_byte");

    // Mid-frame reset aborts immediately
    write_byte(8'h5A, 2);
    tick(2000);
    rst = 1'b0;
    #1;
    chk("abort_tx", {15'b0, uart_tx}, 16'h0001);
    chk("abort_led", {15'b0, ledout}, 16'h0000);
    tick(2);
    rst = 1'b1;
    tick(2);
    rd_chk(4'h0, 16'h0000, "abort_status");
    rd_chk(4'h2, 16'h0000, "abort_txreg");
    rb = 8'($urandom);
    write_byte(rb, 1);
    tick(FRAME + 5);
    rd_chk(4'h2, {8'h00, rb}, "post_reset_byte");

    // Randomized frames with stray reads and writes while busy
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      write_byte(rb, $urandom_range(1, 6));
      tick($urandom_range(50, FRAME / 2));
      cs = 1'b1; rd = 1'b1; addr = 4'($urandom_range(0, 15));
      tick(1);
      bus_idle();
      tick($urandom_range(10, 300));
      write_byte(8'($urandom), $urandom_range(1, 4));
      tick(FRAME);
      rd_chk(4'h2, {8'h00, rb}, "rand_byte");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
